// File: rtl/armleocpu_storegen_buffer.sv
// Store realignment and write buffer: realigns right-aligned store data to its byte lanes, builds strobes, queues legal stores.
// Latency: an accepted legal store reaches the bus write channel one cycle later at the earliest; errors pulse one cycle after acceptance.
// Backpressure: req_ready drops when all DEPTH entries are occupied; the bus head is held stable while bus_wready is low.
module armleocpu_storegen_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_data,

  output logic        err_valid,
  output logic        err_missaligned,
  output logic        err_unknowntype,

  output logic        bus_wvalid,
  input  logic        bus_wready,
  output logic [31:0] bus_waddr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,

  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] STORE_BYTE = 2'b00;
  localparam logic [1:0] STORE_HALF = 2'b01;
  localparam logic [1:0] STORE_WORD = 2'b10;

  // One buffered store; the address is kept word-granular since bits [1:0]
  // are folded into the strobe.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             err_valid_q, err_valid_d;
  logic             err_miss_q,  err_miss_d;
  logic             err_unk_q,   err_unk_d;

  logic [1:0] offset;
  logic       is_unknown;
  logic       is_missaligned;
  logic       accept;
  logic       push;
  logic       pop;
  entry_t     new_entry;
  entry_t     head;

  assign offset = req_addr[1:0];

  // Request classification; an unknown type never also reports misalignment.
  always_comb begin
    is_unknown     = (req_type == 2'b11);
    is_missaligned = 1'b0;
    if (!is_unknown) begin
      if (req_type == STORE_WORD)
        is_missaligned = (offset != 2'b00);
      else if (req_type == STORE_HALF)
        is_missaligned = offset[0];
    end
  end

  assign req_ready = (count_q != CNT_W'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = accept && !is_unknown && !is_missaligned;
  assign bus_wvalid = (count_q != '0);
  assign pop       = bus_wvalid && bus_wready;
  assign empty     = (count_q == '0);

  // Lane realignment: data is replicated across the word so the strobe alone
  // selects which copy the bus writes.
  always_comb begin
    new_entry.word_addr = req_addr[31:2];
    new_entry.wdata     = req_data;
    new_entry.wstrb     = 4'b1111;
    case (req_type)
      STORE_BYTE: begin
        new_entry.wdata = {4{req_data[7:0]}};
        new_entry.wstrb = 4'b0001 << offset;
      end
      STORE_HALF: begin
        new_entry.wdata = {2{req_data[15:0]}};
        new_entry.wstrb = 4'b0011 << offset;
      end
      default: begin
        new_entry.wdata = req_data;
        new_entry.wstrb = 4'b1111;
      end
    endcase
  end

  // Next-state for pointers, occupancy and the one-cycle error pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_valid_d = accept && (is_unknown || is_missaligned);
    err_unk_d   = accept && is_unknown;
    err_miss_d  = accept && is_missaligned;
  end

  // Control state; pending entries are discarded by resetting the occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_valid_q <= 1'b0;
      err_miss_q  <= 1'b0;
      err_unk_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_valid_q <= err_valid_d;
      err_miss_q  <= err_miss_d;
      err_unk_q   <= err_unk_d;
    end
  end

  // Entry storage; contents are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= new_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign bus_waddr = {head.word_addr, 2'b00};
  assign bus_wdata = head.wdata;
  assign bus_wstrb = head.wstrb;

  assign err_valid       = err_valid_q;
  assign err_missaligned = err_miss_q;
  assign err_unknowntype = err_unk_q;

endmodule

// File: tb/tb_armleocpu_storegen_buffer.sv
// Bench for the store realignment buffer: directed literal scenarios plus random traffic,
// all outputs compared every cycle against a queue-based model of the store rules.
module tb_armleocpu_storegen_buffer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_type;
  logic [31:0] req_data;
  logic        err_valid, err_missaligned, err_unknowntype;
  logic        bus_wvalid, bus_wready;
  logic [31:0] bus_waddr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        empty;

  armleocpu_storegen_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_type(req_type), .req_data(req_data),
    .err_valid(err_valid), .err_missaligned(err_missaligned), .err_unknowntype(err_unknowntype),
    .bus_wvalid(bus_wvalid), .bus_wready(bus_wready), .bus_waddr(bus_waddr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .empty(empty)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  ent_t mq[$];
  bit   m_err, m_mis, m_unk;

  bit   t_acc, t_pop, t_unk, t_mis;
  int   t_sz, t_off;
  ent_t t_e;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_err = 0; m_mis = 0; m_unk = 0;
    end else begin
      t_acc = req_valid && (mq.size() < DEPTH);
      t_pop = (mq.size() != 0) && bus_wready;
      t_unk = (req_type == 2'b11);
      t_sz  = 1 << req_type;
      t_off = int'(req_addr % 4);
      t_mis = !t_unk && ((req_addr % t_sz) != 0);
      t_e.addr = req_addr & 32'hFFFF_FFFC;
      for (int lane = 0; lane < 4; lane++) begin
        t_e.strb[lane] = (lane >= t_off) && (lane < t_off + t_sz);
        t_e.data[8*lane +: 8] = req_data[8*(lane % t_sz) +: 8];
      end
      m_err = t_acc && (t_unk || t_mis);
      m_mis = m_err && t_mis;
      m_unk = m_err && t_unk;
      if (t_pop) void'(mq.pop_front());
      if (t_acc && !t_unk && !t_mis) mq.push_back(t_e);
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial forever begin
    @(negedge clk);
    chk("req_ready",  {31'd0, req_ready},  {31'd0, mq.size() != DEPTH});
    chk("bus_wvalid", {31'd0, bus_wvalid}, {31'd0, mq.size() != 0});
    chk("empty",      {31'd0, empty},      {31'd0, mq.size() == 0});
    chk("err_valid",  {31'd0, err_valid},  {31'd0, m_err});
    chk("err_miss",   {31'd0, err_missaligned}, {31'd0, m_mis});
    chk("err_unk",    {31'd0, err_unknowntype}, {31'd0, m_unk});
    if (mq.size() != 0) begin
      chk("head_addr", bus_waddr, mq[0].addr);
      chk("head_data", bus_wdata, mq[0].data);
      chk("head_strb", {28'd0, bus_wstrb}, {28'd0, mq[0].strb});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic v, input logic [31:0] a, input logic [1:0] t,
                     input logic [31:0] d, input logic wr);
    req_valid  = v;
    req_addr   = a;
    req_type   = t;
    req_data   = d;
    bus_wready = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 32'h0, 2'b00, 32'h0, 0);

    // Reset state
    @(negedge clk);
    chk("rst_wvalid", {31'd0, bus_wvalid}, 32'd0);
    chk("rst_empty",  {31'd0, empty},      32'd1);
    chk("rst_ready",  {31'd0, req_ready},  32'd1);
    chk("rst_err",    {31'd0, err_valid},  32'd0);
    step();
    rst_n = 1'b1;

    // Byte store to the top lane
    step();
    drv(1, 32'h1003, 2'b00, 32'h0000_00AB, 1);
    step();
    req_valid = 0;
    @(negedge clk);
    chk("byte_addr", bus_waddr, 32'h0000_1000);
    chk("byte_data", bus_wdata, 32'hABAB_ABAB);
    chk("byte_strb", {28'd0, bus_wstrb}, 32'h8);
    chk("byte_nempty", {31'd0, empty}, 32'd0);
    step();
    @(negedge clk);
    chk("byte_empty", {31'd0, empty}, 32'd1);

    // Half then word, with the bus stalled for the first edge
    step();
    drv(1, 32'h2002, 2'b01, 32'h0000_1234, 0);
    step();
    drv(1, 32'h2004, 2'b10, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("half_data", bus_wdata, 32'h1234_1234);
    chk("half_strb", {28'd0, bus_wstrb}, 32'hC);
    step();
    req_valid = 0;
    bus_wready = 1;
    step();
    @(negedge clk);
    chk("word_addr", bus_waddr, 32'h0000_2004);
    chk("word_data", bus_wdata, 32'hDEAD_BEEF);
    chk("word_strb", {28'd0, bus_wstrb}, 32'hF);
    step();

    // Misaligned word, then unknown type
    drv(1, 32'h3001, 2'b10, 32'h5555_5555, 1);
    step();
    req_valid = 0;
    @(negedge clk);
    chk("mis_err",  {31'd0, err_valid},       32'd1);
    chk("mis_flag", {31'd0, err_missaligned}, 32'd1);
    chk("mis_unk",  {31'd0, err_unknowntype}, 32'd0);
    chk("mis_wv",   {31'd0, bus_wvalid},      32'd0);
    step();
    @(negedge clk);
    chk("mis_pulse", {31'd0, err_valid}, 32'd0);
    step();
    drv(1, 32'h3001, 2'b11, 32'h5555_5555, 1);
    step();
    req_valid = 0;
    @(negedge clk);
    chk("unk_err",  {31'd0, err_valid},       32'd1);
    chk("unk_flag", {31'd0, err_unknowntype}, 32'd1);
    chk("unk_mis",  {31'd0, err_missaligned}, 32'd0);
    step();

    // Fill to DEPTH with the bus stalled
    drv(1, 32'h5000, 2'b10, 32'h1111_1111, 0);
    step();
    drv(1, 32'h5004, 2'b10, 32'h2222_2222, 0);
    step();
    drv(1, 32'h5008, 2'b10, 32'h3333_3333, 0);
    @(negedge clk);
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_addr", bus_waddr, 32'h0000_5000);
      chk("hold_data", bus_wdata, 32'h1111_1111);
    end
    step();
    bus_wready = 1;
    step();
    @(negedge clk);
    chk("drain1_addr", bus_waddr, 32'h0000_5004);
    chk("drain1_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 0;
    @(negedge clk);
    chk("drain2_addr", bus_waddr, 32'h0000_5008);
    chk("drain2_data", bus_wdata, 32'h3333_3333);
    step();
    @(negedge clk);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Streaming one word per cycle, wrapping the pointers several times
    step();
    drv(1, 32'h6000, 2'b10, 32'h0, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 9) drv(1, 32'h6000 + 32'(4 * (i + 1)), 2'b10, 32'(i + 1) * 32'h0101_0101, 1);
      else req_valid = 0;
      @(negedge clk);
      chk("stream_addr", bus_waddr, 32'h6000 + 32'(4 * i));
      chk("stream_wv", {31'd0, bus_wvalid}, 32'd1);
    end
    step();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drv($urandom_range(0, 3) != 0, $urandom(), 2'($urandom_range(0, 3)),
          $urandom(), $urandom_range(0, 2) != 0);
      step();
    end
    drv(0, 32'h0, 2'b00, 32'h0, 1);
    repeat (4) step();

    // Asynchronous reset with two entries pending
    drv(1, 32'h7000, 2'b10, 32'hAAAA_0001, 0);
    step();
    drv(1, 32'h7004, 2'b10, 32'hAAAA_0002, 0);
    step();
    req_valid = 0;
    @(negedge clk);
    chk("pre_rst_wv", {31'd0, bus_wvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wvalid", {31'd0, bus_wvalid}, 32'd0);
    chk("arst_empty",  {31'd0, empty},      32'd1);
    chk("arst_ready",  {31'd0, req_ready},  32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus_wready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_wv", {31'd0, bus_wvalid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/armleocpu_storegen_buffer.md
Name: armleocpu_storegen_buffer

Overview:
Store-side counterpart of the load realignment path. Takes right-aligned store data from the execute stage and realigns it to its address within the bus word. Generates byte write strobes and detects misaligned or unknown store types. Legal stores are held in a small FIFO and drained to the data-bus write channel with a valid/ready handshake.

Parameters:
DEPTH, 2, number of buffered store entries; power of two, 1..8.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  store request valid
req_ready  output  1  buffer can accept a request this cycle
req_addr  input  32  byte address of store
req_type  input  2  store type, `STORE_BYTE=2'b00, `STORE_HALF=2'b01, `STORE_WORD=2'b10, 2'b11 unknown
req_data  input  32  right-aligned store data
err_valid  output  1  one-cycle pulse: a rejected request was accepted last cycle
err_missaligned  output  1  rejection cause: misaligned (valid with err_valid)
err_unknowntype  output  1  rejection cause: unknown type (valid with err_valid)
bus_wvalid  output  1  write request valid (FIFO non-empty)
bus_wready  input  1  bus accepts write
bus_waddr  output  32  word-aligned address, bits [1:0] always 0
bus_wdata  output  32  lane-aligned write data
bus_wstrb  output  4  byte-lane strobes
empty  output  1  no stores pending (used for fence/flush completion)

Behaviour:
- Reset values (async, rst_n low): FIFO pointers/count 0, bus_wvalid 0, empty 1, err_valid 0, err_missaligned 0, err_unknowntype 0. req_ready 1 once count is 0. Entries pending at reset are discarded. bus_waddr/wdata/wstrb are don't-care while bus_wvalid=0.
- req_ready = (count != DEPTH). It is purely state-based and does not depend on bus_wready or req_valid.
- Accept = req_valid && req_ready. An accepted request is classified with offset=req_addr[1:0]:
  - unknown: req_type=2'b11.
  - misaligned: WORD with offset!=0, or HALF with offset[0]=1. BYTE is never misaligned.
  - unknown takes precedence: an unknown type reports unknowntype=1 and missaligned=0.
- Legal accepted request: push one entry.
  - Address: {req_addr[31:2],2'b00}.
  - Data: BYTE → {4{req_data[7:0]}}, HALF → {2{req_data[15:0]}}, WORD → req_data.
  - Strobe: BYTE → 4'b0001<<offset, HALF → 4'b0011<<offset, WORD → 4'b1111.
- Illegal accepted request: nothing is pushed. On the next cycle err_valid=1 with the cause flags registered, for exactly one cycle. Otherwise err_valid=0 and both flags are 0.
- Bus side:
  - bus_wvalid = (count!=0); outputs present the head entry.
  - Pop on bus_wvalid && bus_wready.
  - Head outputs stay stable while bus_wvalid && !bus_wready.
- Latency: an accepted legal store appears on the bus no earlier than the next cycle. There is no combinational path from req_* to bus_*.
- Simultaneous push and pop: count unchanged, pointers both advance and wrap modulo DEPTH. Push at full cannot occur because req_ready=0. A pop at full frees the slot only from the following cycle.
- empty = (count==0); it goes high the cycle after the last pop.
- Stores drain strictly in acceptance order.

Test Plan:
- Byte store addr=0x1003, data=0xAB, bus_wready=1 → next cycle waddr=0x1000, wdata=0xABABABAB, wstrb=4'b1000; empty returns 1 one cycle after the pop.
- Half store addr=0x2002, data=0x1234 → wdata=0x12341234, wstrb=4'b1100. Word store addr=0x2004, data=0xDEADBEEF → wstrb=4'b1111, waddr=0x2004.
- Word store addr=0x3001 → not pushed; next cycle err_valid=1, err_missaligned=1, err_unknowntype=0; bus_wvalid stays 0. Type 2'b11 at addr=0x3001 → err_unknowntype=1, err_missaligned=0.
- DEPTH=2 with bus_wready=0 and three back-to-back requests:
  - The first two are accepted; req_ready=0 on the third.
  - Head is held stable for 5 cycles.
  - Raising bus_wready drains the two entries in order; the third is accepted after the first pop.
- Continuous streaming with req_valid=1 and bus_wready=1: one store per cycle with count steady at 1, plus a pointer-wraparound check over 10 stores.
- Assert rst_n low with 2 entries pending → bus_wvalid=0, empty=1, req_ready=1 immediately (async); no stale write appears after reset release.
